clock_set_ctrl: RTL and testbench
=================================

CLOCK_SET_CTRL -- requirements
Module: clock_set_ctrl

Interface
REQ-001 SHALL have parameter HOUR_CNT, default 24, hours per day (hour field wraps HOUR_CNT-1 -> 0).
REQ-002 SHALL have parameter MIN_CNT, default 60, minutes per hour (minute field wraps MIN_CNT-1 -> 0).
REQ-003 SHALL have parameter TIMEOUT_S, default 30, TICKs without a button press before an edit is abandoned.
REQ-004 SHALL have parameter ALARM_LEN, default 60, maximum TICKs ALARM stays asserted.
REQ-005 CLK  input  1  single clock, all state on rising edge.
REQ-006 RST_N  input  1  asynchronous, active-low reset.
REQ-007 TICK  input  1  one-cycle 1 Hz enable, the same pulse that advances the time counter.
REQ-008 BTN_MODE  input  1  one-cycle debounced pulse: enter, advance or commit an edit.
REQ-009 BTN_INC  input  1  one-cycle debounced pulse: increment the selected field.
REQ-010 CUR_SEC / CUR_MIN / CUR_HOUR  input  6/6/5  live time from the counter.
REQ-011 HOLD  output  1  counter SHALL NOT advance while high.
REQ-012 LOAD  output  1  one-cycle strobe: counter loads LD_HOUR:LD_MIN:00.
REQ-013 LD_MIN / LD_HOUR  output  6/5  load values, valid while LOAD is high.
REQ-014 FIELD  output  3  current state encoding (display blink select).
REQ-015 ALARM  output  1  alarm annunciator.

Function
REQ-016 SHALL implement states RUN(000), SET_HOUR(001), SET_MIN(010), SET_AHOUR(011), SET_AMIN(100); FIELD SHALL equal the state code.
REQ-017 In RUN, BTN_MODE SHALL capture CUR_HOUR/CUR_MIN into edit registers and go to SET_HOUR on the next cycle.
REQ-018 In SET_HOUR, BTN_INC SHALL increment edit hour modulo HOUR_CNT; BTN_MODE SHALL go to SET_MIN.
REQ-019 In SET_MIN, BTN_INC SHALL increment edit minute modulo MIN_CNT; BTN_MODE SHALL pulse LOAD for exactly one cycle with LD_HOUR/LD_MIN = edit registers and leave SET_MIN.
REQ-020 HOLD SHALL be 1 in every SET_* state and 0 in RUN; LOAD SHALL never be asserted in RUN.
REQ-021 BTN_MODE and BTN_INC in the same cycle: BTN_MODE SHALL act, BTN_INC SHALL be discarded.
REQ-022 In any SET_* state, an inactivity counter SHALL count TICKs, clear on any button, and on reaching TIMEOUT_S SHALL return to RUN with no LOAD and no alarm-register change.
REQ-023 LD_MIN/LD_HOUR SHALL hold the edit registers at all times; only LOAD qualifies them.
REQ-024 Edit registers SHALL never exceed HOUR_CNT-1 / MIN_CNT-1.

Reset
REQ-025 RST_N low SHALL immediately force state RUN, HOLD=0, LOAD=0, ALARM=0, FIELD=000, edit and alarm registers 0, armed flag 0, inactivity and alarm counters 0.
REQ-026 Reset asserted mid-edit SHALL discard the edit; no LOAD SHALL be issued after release.

Configuration
REQ-027 Macro CLOCK_SET_CTRL_ALARM_EN SHALL compile in the alarm feature.
REQ-028 With it: BTN_MODE in SET_MIN SHALL pulse LOAD and go to SET_AHOUR; SET_AHOUR/SET_AMIN SHALL edit alarm hour/minute like REQ-018/019; BTN_MODE in SET_AMIN SHALL return to RUN; BTN_INC in RUN SHALL toggle the armed flag.
REQ-029 With it: when armed, in RUN, on TICK with CUR_HOUR/CUR_MIN equal alarm registers and CUR_SEC==0, ALARM SHALL rise next cycle; ALARM SHALL fall on any button (consumed, no other effect; no arm toggle) or after ALARM_LEN TICKs.
REQ-030 Without it: BTN_MODE in SET_MIN SHALL pulse LOAD and return to RUN; ALARM SHALL be constant 0; BTN_INC in RUN SHALL be ignored; states 011/100 unreachable.

Verification
REQ-031 RUN at 13:45, MODE, INC x3, MODE, INC x2, MODE -> LOAD one cycle with LD_HOUR=16, LD_MIN=47; HOLD 1 throughout edit, 0 after.
REQ-032 SET_HOUR edit=23, INC -> edit hour 0; SET_MIN edit=59, INC -> edit minute 0.
REQ-033 SET_MIN, 30 TICKs with no button -> RUN, LOAD never asserted, HOLD=0.
REQ-034 MODE and INC same cycle in SET_HOUR -> SET_MIN, edit hour unchanged.
REQ-035 ALARM_EN: alarm 07:00 armed, CUR 07:00:00 with TICK -> ALARM=1 next cycle; INC -> ALARM=0, still armed; untouched -> ALARM=0 after 60 TICKs.
REQ-036 RST_N low during SET_MIN -> all outputs reset immediately; after release no LOAD, FIELD=000.

Source files
------------

// File: rtl/clock_set_ctrl.sv
// Time/alarm setting controller: captures live time, edits hour/min, loads counter on commit.
// Optional alarm feature compiled in with macro CLOCK_SET_CTRL_ALARM_EN.
module clock_set_ctrl #(
  parameter int HOUR_CNT  = 24,
  parameter int MIN_CNT   = 60,
  parameter int TIMEOUT_S = 30,
  parameter int ALARM_LEN = 60
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_tick,
  input  logic       i_btn_mode,
  input  logic       i_btn_inc,
  input  logic [5:0] i_cur_sec,
  input  logic [5:0] i_cur_min,
  input  logic [4:0] i_cur_hour,
  output logic       o_hold,
  output logic       o_load,
  output logic [5:0] o_ld_min,
  output logic [4:0] o_ld_hour,
  output logic [2:0] o_field,
  output logic       o_alarm
);

  typedef enum logic [2:0] {
    RUN       = 3'b000,
    SET_HOUR  = 3'b001,
    SET_MIN   = 3'b010,
    SET_AHOUR = 3'b011,
    SET_AMIN  = 3'b100
  } state_t;

  localparam int TO_W = $clog2(TIMEOUT_S + 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [4:0]       r_ed_hour;
  logic [5:0]       r_ed_min;
  logic [TO_W-1:0]  r_idle;
  logic             w_btn;
  logic             w_timeout;
  logic             w_cap;
  logic             w_inc_hour;
  logic             w_inc_min;
  logic             w_load;
  logic [4:0]       w_cap_hour;
  logic [5:0]       w_cap_min;

`ifdef CLOCK_SET_CTRL_ALARM_EN
  localparam int AL_W = $clog2(ALARM_LEN + 1);

  logic [4:0]       r_al_hour;
  logic [5:0]       r_al_min;
  logic             r_armed;
  logic             r_alarm;
  logic [AL_W-1:0]  r_al_cnt;
  logic             w_cp_alarm;
  logic             w_commit;
  logic             w_toggle;
  logic             w_alarm_clr;
  logic             w_trigger;
`else
  logic             w_unused;
  assign w_unused = (^i_cur_sec) ^ (ALARM_LEN == 0);
`endif

  assign w_btn      = i_btn_mode | i_btn_inc;
  assign w_timeout  = i_tick && (r_idle == TO_W'(TIMEOUT_S - 1));
  // Out-of-range live values are clamped so edit registers stay legal.
  assign w_cap_hour = (int'(i_cur_hour) < HOUR_CNT) ? i_cur_hour : 5'd0;
  assign w_cap_min  = (int'(i_cur_min)  < MIN_CNT)  ? i_cur_min  : 6'd0;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= RUN;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cap       = 1'b0;
    w_inc_hour  = 1'b0;
    w_inc_min   = 1'b0;
    w_load      = 1'b0;
`ifdef CLOCK_SET_CTRL_ALARM_EN
    w_cp_alarm  = 1'b0;
    w_commit    = 1'b0;
    w_toggle    = 1'b0;
    w_alarm_clr = 1'b0;
`endif
    case (r_state)
      RUN: begin
`ifdef CLOCK_SET_CTRL_ALARM_EN
        // A ringing alarm swallows the button entirely.
        if (r_alarm && w_btn) begin
          w_alarm_clr = 1'b1;
        end else if (i_btn_mode) begin
          w_cap       = 1'b1;
          w_state_nxt = SET_HOUR;
        end else if (i_btn_inc) begin
          w_toggle = 1'b1;
        end
`else
        if (i_btn_mode) begin
          w_cap       = 1'b1;
          w_state_nxt = SET_HOUR;
        end
`endif
      end
      SET_HOUR: begin
        if (i_btn_mode)     w_state_nxt = SET_MIN;
        else if (i_btn_inc) w_inc_hour  = 1'b1;
        else if (w_timeout) w_state_nxt = RUN;
      end
      SET_MIN: begin
        if (i_btn_mode) begin
          w_load = 1'b1;
`ifdef CLOCK_SET_CTRL_ALARM_EN
          w_cp_alarm  = 1'b1;
          w_state_nxt = SET_AHOUR;
`else
          w_state_nxt = RUN;
`endif
        end else if (i_btn_inc) begin
          w_inc_min = 1'b1;
        end else if (w_timeout) begin
          w_state_nxt = RUN;
        end
      end
`ifdef CLOCK_SET_CTRL_ALARM_EN
      SET_AHOUR: begin
        if (i_btn_mode)     w_state_nxt = SET_AMIN;
        else if (i_btn_inc) w_inc_hour  = 1'b1;
        else if (w_timeout) w_state_nxt = RUN;
      end
      SET_AMIN: begin
        if (i_btn_mode) begin
          w_commit    = 1'b1;
          w_state_nxt = RUN;
        end else if (i_btn_inc) begin
          w_inc_min = 1'b1;
        end else if (w_timeout) begin
          w_state_nxt = RUN;
        end
      end
`endif
      default: w_state_nxt = RUN;
    endcase
  end

  // Edit registers are shared between time and alarm editing.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ed_hour <= 5'd0;
      r_ed_min  <= 6'd0;
    end else if (w_cap) begin
      r_ed_hour <= w_cap_hour;
      r_ed_min  <= w_cap_min;
`ifdef CLOCK_SET_CTRL_ALARM_EN
    end else if (w_cp_alarm) begin
      r_ed_hour <= r_al_hour;
      r_ed_min  <= r_al_min;
`endif
    end else if (w_inc_hour) begin
      r_ed_hour <= (r_ed_hour == 5'(HOUR_CNT - 1)) ? 5'd0 : r_ed_hour + 5'd1;
    end else if (w_inc_min) begin
      r_ed_min  <= (r_ed_min == 6'(MIN_CNT - 1)) ? 6'd0 : r_ed_min + 6'd1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      r_idle <= '0;
    else if (r_state == RUN || w_btn || w_state_nxt == RUN)
      r_idle <= '0;
    else if (i_tick)
      r_idle <= r_idle + TO_W'(1);
  end

`ifdef CLOCK_SET_CTRL_ALARM_EN
  assign w_trigger = r_armed && !r_alarm && (r_state == RUN) && i_tick && !w_btn &&
                     (i_cur_hour == r_al_hour) && (i_cur_min == r_al_min) &&
                     (i_cur_sec == 6'd0);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_al_hour <= 5'd0;
      r_al_min  <= 6'd0;
      r_armed   <= 1'b0;
    end else begin
      if (w_commit) begin
        r_al_hour <= r_ed_hour;
        r_al_min  <= r_ed_min;
      end
      if (w_toggle) r_armed <= ~r_armed;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_alarm  <= 1'b0;
      r_al_cnt <= '0;
    end else if (w_alarm_clr) begin
      r_alarm  <= 1'b0;
      r_al_cnt <= '0;
    end else if (r_alarm && i_tick) begin
      if (r_al_cnt == AL_W'(ALARM_LEN - 1)) begin
        r_alarm  <= 1'b0;
        r_al_cnt <= '0;
      end else begin
        r_al_cnt <= r_al_cnt + AL_W'(1);
      end
    end else if (w_trigger) begin
      r_alarm  <= 1'b1;
      r_al_cnt <= '0;
    end
  end

  assign o_alarm = r_alarm;
`else
  assign o_alarm = 1'b0;
`endif

  assign o_hold    = (r_state != RUN);
  assign o_load    = w_load;
  assign o_field   = r_state;
  assign o_ld_hour = r_ed_hour;
  assign o_ld_min  = r_ed_min;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Randomized + directed bench for clock_set_ctrl against a behavioural mode/edit model.
module tb_clock_set_ctrl;

`ifdef CLOCK_SET_CTRL_ALARM_EN
  localparam bit ALARM = 1'b1;
`else
  localparam bit ALARM = 1'b0;
`endif
  localparam int HOUR_CNT  = 24;
  localparam int MIN_CNT   = 60;
  localparam int TIMEOUT_S = 30;
  localparam int ALARM_LEN = 60;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tick, btn_mode, btn_inc;
  logic [5:0] cur_sec, cur_min;
  logic [4:0] cur_hour;
  logic       hold, load, alarm;
  logic [5:0] ld_min;
  logic [4:0] ld_hour;
  logic [2:0] field;

  clock_set_ctrl #(
    .HOUR_CNT(HOUR_CNT), .MIN_CNT(MIN_CNT), .TIMEOUT_S(TIMEOUT_S), .ALARM_LEN(ALARM_LEN)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_tick(tick), .i_btn_mode(btn_mode), .i_btn_inc(btn_inc),
    .i_cur_sec(cur_sec), .i_cur_min(cur_min), .i_cur_hour(cur_hour),
    .o_hold(hold), .o_load(load), .o_ld_min(ld_min), .o_ld_hour(ld_hour),
    .o_field(field), .o_alarm(alarm)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: mode number 0..4, edit values, alarm settings, timers.
  int m_mode, m_eh, m_em, m_ah, m_am, m_idle, m_acnt;
  bit m_armed, m_alarm;

  int c_hour, c_min, c_sec;
  logic [2:0] s_field;
  logic       s_hold, s_load, s_alarm;
  logic [4:0] s_ld_hour;
  logic [5:0] s_ld_min;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0d, expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_eh = 0; m_em = 0; m_ah = 0; m_am = 0;
    m_idle = 0; m_acnt = 0; m_armed = 0; m_alarm = 0;
  endtask

  task automatic model_step(input bit mode, input bit inc, input bit tk);
    bit btn, al_old, arm_old;
    btn = mode | inc;
    al_old = m_alarm;
    arm_old = m_armed;
    if (m_mode == 0) begin
      if (ALARM && al_old && btn) begin
        m_alarm = 0;
        m_acnt = 0;
      end else begin
        if (mode) begin
          m_eh = c_hour; m_em = c_min; m_mode = 1; m_idle = 0;
        end else if (inc && ALARM) begin
          m_armed = !m_armed;
        end
        if (ALARM && al_old && tk) begin
          m_acnt++;
          if (m_acnt == ALARM_LEN) begin m_alarm = 0; m_acnt = 0; end
        end else if (ALARM && !al_old && arm_old && tk && !btn &&
                     c_hour == m_ah && c_min == m_am && c_sec == 0) begin
          m_alarm = 1; m_acnt = 0;
        end
      end
    end else if (mode) begin
      m_idle = 0;
      case (m_mode)
        1: m_mode = 2;
        2: if (ALARM) begin m_eh = m_ah; m_em = m_am; m_mode = 3; end else m_mode = 0;
        3: m_mode = 4;
        default: begin m_ah = m_eh; m_am = m_em; m_mode = 0; end
      endcase
    end else if (inc) begin
      m_idle = 0;
      if (m_mode == 1 || m_mode == 3) m_eh = (m_eh + 1) % HOUR_CNT;
      else                            m_em = (m_em + 1) % MIN_CNT;
    end else if (tk) begin
      m_idle++;
      if (m_idle == TIMEOUT_S) begin m_mode = 0; m_idle = 0; end
    end
  endtask

  task automatic cyc(input bit mode, input bit inc, input bit tk);
    @(negedge clk);
    btn_mode = mode; btn_inc = inc; tick = tk;
    cur_hour = 5'(c_hour); cur_min = 6'(c_min); cur_sec = 6'(c_sec);
    #2;
    s_field = field; s_hold = hold; s_load = load; s_alarm = alarm;
    s_ld_hour = ld_hour; s_ld_min = ld_min;
    chk("field", field, m_mode);
    chk("hold", hold, m_mode != 0);
    chk("load", load, (m_mode == 2) && mode);
    chk("ld_hour", ld_hour, m_eh);
    chk("ld_min", ld_min, m_em);
    chk("alarm", alarm, m_alarm);
    @(posedge clk);
    model_step(mode, inc, tk);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_field"}, field, 0);
    chk({tag, "_hold"}, hold, 0);
    chk({tag, "_load"}, load, 0);
    chk({tag, "_alarm"}, alarm, 0);
    chk({tag, "_ldh"}, ld_hour, 0);
    chk({tag, "_ldm"}, ld_min, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; tick = 0; btn_mode = 0; btn_inc = 0;
    cur_sec = 0; cur_min = 0; cur_hour = 0;
    c_hour = 0; c_min = 0; c_sec = 0;
    model_reset();
    #3;
    check_reset_outputs("por");
    @(negedge clk);
    rst_n = 1'b1;

    // Worked example: 13:45 -> 16:47
    c_hour = 13; c_min = 45; c_sec = 10;
    cyc(1, 0, 0);
    repeat (3) cyc(0, 1, 0);
    cyc(1, 0, 0);
    repeat (2) cyc(0, 1, 0);
    cyc(1, 0, 0);
    chk("ex_load", s_load, 1);
    chk("ex_ldh", s_ld_hour, 16);
    chk("ex_ldm", s_ld_min, 47);
    chk("ex_hold_in", s_hold, 1);
    cyc(0, 0, 0);
    chk("ex_load_after", s_load, 0);
    chk("ex_hold_after", s_hold, ALARM);
    repeat (TIMEOUT_S) cyc(0, 0, 1);

    // Wrap boundaries
    c_hour = 23; c_min = 59;
    cyc(1, 0, 0);
    cyc(0, 1, 0);
    cyc(0, 0, 0);
    chk("wrap_hour", s_ld_hour, 0);
    cyc(1, 0, 0);
    cyc(0, 1, 0);
    cyc(0, 0, 0);
    chk("wrap_min", s_ld_min, 0);

    // Inactivity timeout from SET_MIN
    repeat (TIMEOUT_S - 1) cyc(0, 0, 1);
    cyc(0, 0, 0);
    chk("to_before", s_field, 2);
    cyc(0, 0, 1);
    cyc(0, 0, 0);
    chk("to_field", s_field, 0);
    chk("to_hold", s_hold, 0);

    // MODE+INC together: MODE wins
    c_hour = 5; c_min = 10;
    cyc(1, 0, 0);
    cyc(1, 1, 0);
    cyc(0, 0, 0);
    chk("both_field", s_field, 2);
    chk("both_hour", s_ld_hour, 5);
    repeat (TIMEOUT_S) cyc(0, 0, 1);

    // Reset in the middle of an edit
    c_hour = 9; c_min = 30;
    cyc(1, 0, 0);
    cyc(1, 0, 0);
    @(negedge clk);
    rst_n = 1'b0; btn_mode = 1'b1;
    #1;
    check_reset_outputs("mid");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1; btn_mode = 1'b0;
    cyc(0, 0, 0);
    chk("rel_field", s_field, 0);
    chk("rel_load", s_load, 0);

`ifdef CLOCK_SET_CTRL_ALARM_EN
    // Set alarm to 07:00 and arm it
    c_hour = 7; c_min = 0; c_sec = 30;
    cyc(1, 0, 0);
    cyc(1, 0, 0);
    cyc(1, 0, 0);
    repeat (7) cyc(0, 1, 0);
    cyc(1, 0, 0);
    cyc(1, 0, 0);
    cyc(0, 1, 0);
    c_sec = 0;
    cyc(0, 0, 1);
    cyc(0, 0, 0);
    chk("al_rise", s_alarm, 1);
    cyc(0, 1, 0);
    cyc(0, 0, 0);
    chk("al_clr", s_alarm, 0);
    chk("al_clr_field", s_field, 0);
    cyc(0, 0, 1);
    cyc(0, 0, 0);
    chk("al_rearm", s_alarm, 1);
    c_sec = 1;
    repeat (ALARM_LEN - 1) cyc(0, 0, 1);
    cyc(0, 0, 0);
    chk("al_hold", s_alarm, 1);
    cyc(0, 0, 1);
    cyc(0, 0, 0);
    chk("al_expire", s_alarm, 0);
`endif

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      c_hour = int'($urandom % HOUR_CNT);
      c_min  = int'($urandom % MIN_CNT);
      c_sec  = ($urandom % 4 == 0) ? 0 : int'($urandom % 60);
      cyc(($urandom % 8) == 0, ($urandom % 3) == 0, ($urandom % 4) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
